// File: rtl/booth_pp_accumulator_if.sv
// Handshake and data bundle between the Booth partial-product generator,
// the sequential accumulator and the downstream normalisation stage.
interface booth_pp_accumulator_if #(
  parameter int PARM_MANT = 23,
  parameter int PARM_PP   = 13
);
  localparam int PP_W   = 2 * PARM_MANT + 3;
  localparam int PROD_W = 2 * PARM_MANT + 2;

  logic                      valid_i;
  logic                      ready_o;
  logic [PARM_PP*PP_W-1:0]   pp_flat_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [PROD_W-1:0]         product_o;
  logic                      busy_o;

  // master drives a partial-product set and consumes the product
  modport master (
    output valid_i, pp_flat_i, ready_i,
    input  ready_o, valid_o, product_o, busy_o
  );

  modport slave (
    input  valid_i, pp_flat_i, ready_i,
    output ready_o, valid_o, product_o, busy_o
  );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Multi-cycle Booth partial-product reducer: one 3:2 CSA step per cycle into a
// sum/carry pair, then a single carry-propagate add to the mantissa product.
module booth_pp_accumulator #(
  parameter int PARM_MANT = 23,
  parameter int PARM_PP   = 13
) (
  input logic                    clk_i,
  input logic                    rst_i,
  booth_pp_accumulator_if.slave  bus
);
  localparam int PP_W   = 2 * PARM_MANT + 3;
  localparam int PROD_W = 2 * PARM_MANT + 2;
  localparam int CNT_W  = $clog2(PARM_PP);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t             state;
  logic [PP_W-1:0]    pp_bank [PARM_PP];
  logic [PP_W-1:0]    sum_q;
  logic [PP_W-1:0]    carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  product_q;
  logic               valid_q;
  logic               ready_q;
  logic               busy_q;

  logic [PP_W-1:0]    csa_sum;
  logic [PP_W-1:0]    csa_maj;
  logic [PP_W-1:0]    csa_carry;
  logic [PP_W-1:0]    resolved;

  // The bank shifts down each ACCUM cycle, so the CSA always consumes entry 0
  // and no 13:1 read mux is needed.
  assign csa_sum   = sum_q ^ carry_q ^ pp_bank[0];
  assign csa_maj   = (sum_q & carry_q) | (sum_q & pp_bank[0]) | (carry_q & pp_bank[0]);
  assign csa_carry = {csa_maj[PP_W-2:0], 1'b0};
  assign resolved  = sum_q + carry_q;

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      // NOTE: the bank is reset on purpose so an aborted operation leaves no
      // stale partial products behind; this costs reset fan-out on 637 flops.
      for (int i = 0; i < PARM_PP; i++) pp_bank[i] <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            for (int i = 0; i < PARM_PP; i++) pp_bank[i] <= bus.pp_flat_i[i*PP_W +: PP_W];
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q   <= csa_sum;
          carry_q <= csa_carry;
          for (int i = 0; i < PARM_PP - 1; i++) pp_bank[i] <= pp_bank[i+1];
          pp_bank[PARM_PP-1] <= '0;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PARM_PP - 1)) state <= RESOLVE;
        end
        RESOLVE: begin
          // Dropping the top bit is exact: the Booth sign encoding makes the
          // modular sum equal the true mantissa product.
          product_q <= resolved[PROD_W-1:0];
          valid_q   <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = valid_q;
  assign bus.product_o = product_q;
  assign bus.busy_o    = busy_q;
endmodule
